icache_resp: RTL and testbench

Direct-mapped, blocking instruction cache. It is the responder to the Fetch2 stage's `icache_ready`/`icache_data` interface. It captures the fetch address presented in the Fetch1 cycle and returns the instruction word in the following (Fetch2) cycle on a hit. On a miss it refills one line from the memory read port, holding `icache_ready` low until the word is available.

---
 rtl/icache_resp.sv | 163 ++++++++++++++++
 tb/tb_icache_resp.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_resp.sv
// icache_resp -- direct-mapped, blocking instruction cache that answers the
// Fetch2 stage. The Fetch1 address is captured on every unstalled edge and
// looked up combinationally in the following cycle. A miss refills one whole
// line from the memory read port before the lookup is retried.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_addr, req_valid Fetch1 PC and its qualifier (req_addr[1:0] ignored)
//   is_stall            hold the captured address
//   lookup_kill         captured request is flushed; never refill for it
//   icache_ready        icache_data is valid for the captured address
//   icache_data         instruction word
//   mem_rd_req/addr     line read request and line-aligned address
//   mem_rd_ack          request accepted
//   mem_rd_valid/data   data beat
//   mem_rd_last         final beat of the line
module icache_resp #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req_addr,
  input  logic        req_valid,
  input  logic        is_stall,
  input  logic        lookup_kill,
  output logic        icache_ready,
  output logic [31:0] icache_data,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_ack,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_last
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REFILL
  } state_t;

  state_t state, state_next;

  logic [31:0] a_r;
  logic        v_r;

  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS][LINE_WORDS];
  logic [SETS-1:0]  valid;

  logic [OFF_W-1:0] cnt;

  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_off;
  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             start_fill;
  logic             beat;
  logic             fill_done;

  logic unused_bits;
  assign unused_bits = ^{req_addr[1:0], a_r[1:0]};

  assign a_idx = a_r[OFF_W+2 +: IDX_W];
  assign a_off = a_r[2 +: OFF_W];
  assign a_tag = a_r[31 -: TAG_W];

  // The refill target comes from the latched line base, never from a_r,
  // because a_r may move on to a new PC while the burst is in flight.
  assign fill_idx = mem_rd_addr[OFF_W+2 +: IDX_W];
  assign fill_tag = mem_rd_addr[31 -: TAG_W];

  assign hit        = v_r & valid[a_idx] & (tag_mem[a_idx] == a_tag);
  assign start_fill = (state == IDLE) & v_r & ~hit & ~lookup_kill;
  assign beat       = (state == REFILL) & mem_rd_valid;
  assign fill_done  = beat & mem_rd_last;

  assign icache_data = data_mem[a_idx][a_off];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    icache_ready = 1'b0;
    mem_rd_req   = 1'b0;
    case (state)
      IDLE: begin
        icache_ready = hit;
        if (start_fill) begin
          state_next = REQ;
        end
      end
      REQ: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) begin
          state_next = REFILL;
        end
      end
      REFILL: begin
        if (fill_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      v_r <= 1'b0;
    end else if (!is_stall) begin
      a_r <= req_addr;
      v_r <= req_valid;
    end
  end

  // The line is invalidated as soon as its refill is committed, so a
  // partially written line can never produce a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= '0;
      mem_rd_addr <= '0;
      cnt         <= '0;
    end else begin
      if (start_fill) begin
        mem_rd_addr     <= {a_r[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        valid[a_idx]    <= 1'b0;
      end
      if ((state == REQ) && mem_rd_ack) begin
        cnt <= '0;
      end else if (beat) begin
        cnt <= cnt + 1'b1;
      end
      if (fill_done) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      data_mem[fill_idx][cnt] <= mem_rd_data;
    end
    if (fill_done) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_resp.sv
// tb_icache_resp -- directed, table-driven bench for icache_resp.
// Each vector drives the inputs for one cycle; the listed outputs are the
// values expected just after the following rising edge.
module tb_icache_resp;

  localparam int LW = 4;
  localparam logic [31:0] P0 = 32'h1C000000;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_addr;
  logic        req_valid;
  logic        is_stall;
  logic        lookup_kill;
  logic        icache_ready;
  logic [31:0] icache_data;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ack;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_rd_last;

  int checks;
  int failures;
  int beats;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        valid;
    logic        stall;
    logic        kill;
    logic        ack;
    logic        beat;
    logic        last;
    logic [31:0] bdata;
    logic        exp_ready;
    logic [31:0] exp_data;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  icache_resp #(.LINE_WORDS(LW), .SETS(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_addr     (req_addr),
    .req_valid    (req_valid),
    .is_stall     (is_stall),
    .lookup_kill  (lookup_kill),
    .icache_ready (icache_ready),
    .icache_data  (icache_data),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ack   (mem_rd_ack),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_last  (mem_rd_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(string name, logic [31:0] addr, logic valid,
                               logic stall, logic kill, logic ack, logic bt,
                               logic last, logic [31:0] bdata, logic eready,
                               logic [31:0] edata, logic ereq,
                               logic [31:0] eaddr);
    vec_t v;
    v.name = name; v.addr = addr; v.valid = valid; v.stall = stall;
    v.kill = kill; v.ack = ack; v.beat = bt; v.last = last; v.bdata = bdata;
    v.exp_ready = eready; v.exp_data = edata; v.exp_req = ereq;
    v.exp_addr = eaddr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_addr     = v.addr;
    req_valid    = v.valid;
    is_stall     = v.stall;
    lookup_kill  = v.kill;
    mem_rd_ack   = v.ack;
    mem_rd_valid = v.beat;
    mem_rd_data  = v.bdata;
    mem_rd_last  = v.last;
    // Memory-side protocol: exactly LW beats per burst, last on the final one.
    if (v.ack) beats = 0;
    if (v.beat) begin
      beats++;
      if (v.last) checkOutput({v.name, "/burst_len"}, beats, LW);
    end
    @(posedge clk);
    #1;
    checkOutput({v.name, "/ready"}, {31'b0, icache_ready}, {31'b0, v.exp_ready});
    checkOutput({v.name, "/req"}, {31'b0, mem_rd_req}, {31'b0, v.exp_req});
    if (v.exp_ready) checkOutput({v.name, "/data"}, icache_data, v.exp_data);
    if (v.exp_req) checkOutput({v.name, "/addr"}, mem_rd_addr, v.exp_addr);
  endtask

  initial begin
    checks = 0; failures = 0; beats = 0;
    rst_n = 1'b0;
    req_addr = '0; req_valid = 1'b0; is_stall = 1'b0; lookup_kill = 1'b0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0; mem_rd_last = 1'b0;

    // Cold miss on P0, line filled with A0..A3.
    vecs.push_back(mkv("cold_capture", P0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv("cold_req",     P0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, P0));
    vecs.push_back(mkv("cold_ack",     P0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < LW; i++)
      vecs.push_back(mkv("cold_beat", P0, 1, 1, 0, 0, 1, i == LW-1, 32'hA0 + i,
                         i == LW-1, 32'hA0, 0, 0));
    // Sequential hits, one word per cycle.
    for (int i = 1; i < LW; i++)
      vecs.push_back(mkv("seq_hit", P0 + 4*i, 1, 0, 0, 0, 0, 0, 0, 1, 32'hA0 + i, 0, 0));
    // Stall holds a hit while req_addr moves.
    vecs.push_back(mkv("stall_load", P0,       1, 0, 0, 0, 0, 0, 0, 1, 32'hA0, 0, 0));
    vecs.push_back(mkv("stall_hold", P0 + 8,   1, 1, 0, 0, 0, 0, 0, 1, 32'hA0, 0, 0));
    vecs.push_back(mkv("stall_hold", P0 + 'hC, 1, 1, 0, 0, 0, 0, 0, 1, 32'hA0, 0, 0));
    // Conflict: same index, new tag.
    vecs.push_back(mkv("conf_capture", P0 + 'h400, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv("conf_req",     P0 + 'h400, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, P0 + 'h400));
    vecs.push_back(mkv("conf_ack",     P0 + 'h400, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < LW; i++)
      vecs.push_back(mkv("conf_beat", P0 + 'h400, 1, 1, 0, 0, 1, i == LW-1, 32'hB0 + i,
                         i == LW-1, 32'hB0, 0, 0));
    // Old line was evicted, so P0 misses again.
    vecs.push_back(mkv("reload_capture", P0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv("reload_req",     P0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, P0));
    vecs.push_back(mkv("reload_ack",     P0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < LW; i++)
      vecs.push_back(mkv("reload_beat", P0, 1, 1, 0, 0, 1, i == LW-1, 32'hA0 + i,
                         i == LW-1, 32'hA0, 0, 0));
    // Miss killed in its miss cycle: no refill.
    vecs.push_back(mkv("kill_capture", P0 + 'h10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv("kill_miss",    P0,        0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv("kill_after",   P0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Kill plus new hitting PC during REFILL: burst still completes.
    vecs.push_back(mkv("rf_capture", P0 + 'h10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv("rf_req",     P0 + 'h10, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, P0 + 'h10));
    vecs.push_back(mkv("rf_ack",     P0 + 'h10, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < LW; i++)
      vecs.push_back(mkv("rf_beat", P0, 1, 0, 1, 0, 1, i == LW-1, 32'hD0 + i,
                         i == LW-1, 32'hA0, 0, 0));
    vecs.push_back(mkv("rf_idx1_w1", P0 + 'h14, 1, 0, 0, 0, 0, 0, 0, 1, 32'hD1, 0, 0));
    vecs.push_back(mkv("rf_idx1_w3", P0 + 'h1C, 1, 0, 0, 0, 0, 0, 0, 1, 32'hD3, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset/ready", {31'b0, icache_ready}, 32'd0);
    checkOutput("reset/req",   {31'b0, mem_rd_req},   32'd0);
    checkOutput("reset/addr",  mem_rd_addr,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Slow memory: ack after three wait cycles, a gap between beats.
    applyStimulus(mkv("ws_capture", P0 + 'h20, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      applyStimulus(mkv("ws_req_hold", P0 + 'h20, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, P0 + 'h20));
    applyStimulus(mkv("ws_ack", P0 + 'h20, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < LW; i++) begin
      if (i == 2)
        applyStimulus(mkv("ws_gap", P0 + 'h20, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      applyStimulus(mkv("ws_beat", P0 + 'h20, 1, 1, 0, 0, 1, i == LW-1, 32'hE0 + i,
                        i == LW-1, 32'hE0, 0, 0));
    end

    // Reset asserted mid-refill drops the request at once and clears valid.
    applyStimulus(mkv("rst_capture", P0 + 'h30, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mkv("rst_req",     P0 + 'h30, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, P0 + 'h30));
    applyStimulus(mkv("rst_ack",     P0 + 'h30, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mkv("rst_beat",    P0 + 'h30, 1, 1, 0, 0, 1, 0, 32'hF0, 0, 0, 0, 0));
    #2;
    req_valid = 1'b0; is_stall = 1'b0; lookup_kill = 1'b0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_last = 1'b0;
    rst_n = 1'b0;
    beats = 0;
    #1;
    checkOutput("midrst/ready", {31'b0, icache_ready}, 32'd0);
    checkOutput("midrst/req",   {31'b0, mem_rd_req},   32'd0);
    checkOutput("midrst/addr",  mem_rd_addr,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mkv("postrst_capture", P0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mkv("postrst_req",     P0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, P0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
